moving_avg_rnd: RTL and testbench

MOVING_AVG_RND -- requirements
Module: moving_avg_rnd

---
 rtl/moving_avg_rnd.sv | 112 +++++++++++
 tb/tb_moving_avg_rnd.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/moving_avg_rnd.sv
// Moving average over a 2**LOG2_DEPTH sample window with selectable rounding.
// Keeps a running sum updated incrementally from a circular sample buffer.
module moving_avg_rnd #(
    parameter int unsigned WIDTH      = 10,
    parameter int unsigned LOG2_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       round_mode,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             full
);

    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned SW    = WIDTH + LOG2_DEPTH;
    localparam int unsigned PW    = (LOG2_DEPTH > 0) ? LOG2_DEPTH : 1;
    localparam int unsigned CW    = LOG2_DEPTH + 1;

    logic signed [WIDTH-1:0] win_q [DEPTH];
    logic signed [SW-1:0]    sum_q;
    logic signed [SW-1:0]    sum_nxt;
    logic [PW-1:0]           ptr_q;
    logic [PW-1:0]           ptr_nxt;
    logic [CW-1:0]           fill_q;
    logic [CW-1:0]           fill_nxt;
    logic                    fill_done;
    logic [WIDTH-1:0]        avg;

    // Incremental window update: add the new sample, drop the one it overwrites.
    always_comb begin
        sum_nxt   = sum_q + SW'($signed(in_data)) - SW'(win_q[ptr_q]);
        ptr_nxt   = (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);
        fill_nxt  = (fill_q == CW'(DEPTH)) ? fill_q : fill_q + CW'(1);
        fill_done = (fill_nxt == CW'(DEPTH));
    end

    generate
        if (LOG2_DEPTH == 0) begin : g_pass
            // Single-entry window: the sum is the sample itself.
            always_comb avg = sum_nxt[WIDTH-1:0];
        end else begin : g_round
            localparam logic signed [SW:0] SAT_MAX = (SW+1)'((1 << (WIDTH - 1)) - 1);
            localparam logic signed [SW:0] SAT_MIN = ~SAT_MAX;
            localparam logic [LOG2_DEPTH-1:0] HALF = LOG2_DEPTH'(1 << (LOG2_DEPTH - 1));

            logic signed [SW:0]    q_ext;
            logic signed [SW:0]    res_ext;
            logic [LOG2_DEPTH-1:0] rem;
            logic                  inc;

            always_comb begin
                q_ext = (SW+1)'(sum_nxt >>> LOG2_DEPTH);
                rem   = sum_nxt[LOG2_DEPTH-1:0];
                inc   = 1'b0;
                case (round_mode)
                    2'b01:   inc = (rem >= HALF);
                    2'b10:   inc = (rem > HALF) || ((rem == HALF) && q_ext[0]);
                    default: inc = 1'b0;
                endcase
                res_ext = q_ext + (SW+1)'(inc);
                avg     = res_ext[WIDTH-1:0];
                if (res_ext > SAT_MAX) begin
                    avg = SAT_MAX[WIDTH-1:0];
                end else if (res_ext < SAT_MIN) begin
                    avg = SAT_MIN[WIDTH-1:0];
                end
            end
        end
    endgenerate

    // rst clears everything; flush clears everything except the held result.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q     <= '0;
            ptr_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            full      <= 1'b0;
        end else if (flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                win_q[i] <= '0;
            end
            sum_q     <= '0;
            ptr_q     <= '0;
            fill_q    <= '0;
            out_valid <= 1'b0;
            full      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (in_valid) begin
                win_q[ptr_q] <= in_data;
                sum_q        <= sum_nxt;
                ptr_q        <= ptr_nxt;
                fill_q       <= fill_nxt;
                full         <= fill_done;
                if (fill_done) begin
                    out_valid <= 1'b1;
                    out_data  <= avg;
                end
            end
        end
    end

endmodule

// File: tb/tb_moving_avg_rnd.sv
// Bench for moving_avg_rnd: directed vector table, a hand sequence for rst+flush,
// then randomized traffic against a queue-based window-average model.
module tb_moving_avg_rnd;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [9:0] in_data;
    logic [1:0] round_mode;
    logic       flush;
    logic       out_valid;
    logic [9:0] out_data;
    logic       full;

    int n_checks = 0;
    int n_pass   = 0;

    moving_avg_rnd #(.WIDTH(10), .LOG2_DEPTH(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .round_mode (round_mode),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .full       (full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic       f;
        logic       v;
        int         d;
        logic [1:0] m;
        logic       ev;
        int         ed;
        logic       ef;
    } vec_t;

    vec_t tbl[$];

    // Window model: samples accepted since the last rst/flush, newest at the back.
    int   win[$];
    logic m_valid;
    int   m_data;
    logic m_full;

    task automatic add(input logic r, input logic f, input logic v, input int d,
                       input logic [1:0] m, input logic ev, input int ed, input logic ef);
        vec_t t;
        t.r = r; t.f = f; t.v = v; t.d = d; t.m = m; t.ev = ev; t.ed = ed; t.ef = ef;
        tbl.push_back(t);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic step(input logic r, input logic f, input logic v, input int d,
                        input logic [1:0] m);
        rst        = r;
        flush      = f;
        in_valid   = v;
        in_data    = 10'(d);
        round_mode = m;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic ev, input int ed, input logic ef);
        chk({tag, ".out_valid"}, int'(out_valid), int'(ev));
        chk({tag, ".out_data"},  int'($signed(out_data)), ed);
        chk({tag, ".full"},      int'(full), int'(ef));
    endtask

    // Window average by exact floor division, then the rounding rule on the remainder.
    function automatic int ref_avg(input int s, input logic [1:0] m);
        int q;
        int r;
        q = (s >= 0) ? s / 4 : -((-s + 3) / 4);
        r = s - 4 * q;
        if (m == 2'b01 && r >= 2) q++;
        if (m == 2'b10 && (r > 2 || (r == 2 && (q % 2) != 0))) q++;
        if (q > 511) q = 511;
        if (q < -512) q = -512;
        return q;
    endfunction

    task automatic model(input logic r, input logic f, input logic v, input int d,
                         input logic [1:0] m);
        int s;
        m_valid = 1'b0;
        if (r) begin
            win.delete();
            m_data = 0;
        end else if (f) begin
            win.delete();
        end else if (v) begin
            win.push_back(d);
            if (win.size() > 4) void'(win.pop_front());
            if (win.size() == 4) begin
                s = 0;
                foreach (win[k]) s += win[k];
                m_valid = 1'b1;
                m_data  = ref_avg(s, m);
            end
        end
        m_full = (win.size() == 4);
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; round_mode = '0;

        //   r f v   d    m    ev  ed   ef
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   4, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 0,   0, 0);
        add(0,0,1,  12, 2'd0, 0,   0, 0);
        add(0,0,1,  16, 2'd0, 1,  10, 1);
        add(0,0,1,  20, 2'd0, 1,  14, 1);
        add(0,0,0,   0, 2'd0, 0,  14, 1);
        // sum -6 under each mode
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,  -1, 2'd0, 0,   0, 0);
        add(0,0,1,  -2, 2'd0, 0,   0, 0);
        add(0,0,1,  -1, 2'd0, 0,   0, 0);
        add(0,0,1,  -2, 2'd0, 1,  -2, 1);
        add(0,0,1,  -1, 2'd1, 1,  -1, 1);
        add(0,0,1,  -2, 2'd2, 1,  -2, 1);
        // sum 6
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   1, 2'd0, 0,   0, 0);
        add(0,0,1,   1, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 1,   1, 1);
        add(0,0,1,   1, 2'd1, 1,   2, 1);
        add(0,0,1,   1, 2'd2, 1,   2, 1);
        // sum 10
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 0,   0, 0);
        add(0,0,1,   3, 2'd0, 0,   0, 0);
        add(0,0,1,   3, 2'd0, 1,   2, 1);
        add(0,0,1,   2, 2'd1, 1,   3, 1);
        add(0,0,1,   2, 2'd2, 1,   2, 1);
        // sum 7
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   1, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 0,   0, 0);
        add(0,0,1,   2, 2'd0, 1,   1, 1);
        add(0,0,1,   1, 2'd1, 1,   2, 1);
        add(0,0,1,   2, 2'd2, 1,   2, 1);
        // extremes
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1, 511, 2'd0, 0,   0, 0);
        add(0,0,1, 511, 2'd0, 0,   0, 0);
        add(0,0,1, 511, 2'd0, 0,   0, 0);
        add(0,0,1, 511, 2'd0, 1, 511, 1);
        add(0,0,1, 511, 2'd1, 1, 511, 1);
        add(0,0,1, 511, 2'd2, 1, 511, 1);
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,-512, 2'd0, 0,   0, 0);
        add(0,0,1,-512, 2'd0, 0,   0, 0);
        add(0,0,1,-512, 2'd0, 0,   0, 0);
        add(0,0,1,-512, 2'd0, 1,-512, 1);
        add(0,0,1,-512, 2'd1, 1,-512, 1);
        add(0,0,1,-512, 2'd2, 1,-512, 1);
        // flush with in_valid, then refill
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   4, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 0,   0, 0);
        add(0,0,1,  12, 2'd0, 0,   0, 0);
        add(0,0,1,  16, 2'd0, 1,  10, 1);
        add(0,1,1, 100, 2'd0, 0,  10, 0);
        add(0,0,1,   1, 2'd0, 0,  10, 0);
        add(0,0,1,   2, 2'd0, 0,  10, 0);
        add(0,0,1,   3, 2'd0, 0,  10, 0);
        add(0,0,1,   6, 2'd0, 1,   3, 1);
        // rst mid-window with gaps
        add(1,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   5, 2'd0, 0,   0, 0);
        add(0,0,1,   5, 2'd0, 0,   0, 0);
        add(1,0,1,  99, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 0,   0, 0);
        add(0,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 0,   0, 0);
        add(0,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 0,   0, 0);
        add(0,0,0,   0, 2'd0, 0,   0, 0);
        add(0,0,1,   8, 2'd0, 1,   8, 1);
        add(0,0,0,   0, 2'd0, 0,   8, 1);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].f, tbl[i].v, tbl[i].d, tbl[i].m);
            check_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ef);
        end

        // rst together with flush must clear the held result too
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 40, 2'd0);
        check_out("hand_fill40", 1'b1, 40, 1'b1);
        step(1'b1, 1'b1, 1'b1, 77, 2'd1);
        check_out("hand_rst_flush", 1'b0, 0, 1'b0);

        // randomized traffic against the window model
        win.delete();
        m_data = 0;
        step(1'b1, 1'b0, 1'b0, 0, 2'd0);
        model(1'b1, 1'b0, 1'b0, 0, 2'd0);
        for (int n = 0; n < 3000; n++) begin
            logic       r;
            logic       f;
            logic       v;
            int         d;
            logic [1:0] m;
            r = ($urandom_range(0, 63) == 0);
            f = ($urandom_range(0, 15) == 0);
            v = ($urandom_range(0, 3) != 0);
            d = int'($urandom_range(0, 1023)) - 512;
            m = 2'($urandom_range(0, 3));
            step(r, f, v, d, m);
            model(r, f, v, d, m);
            check_out($sformatf("rnd%0d", n), m_valid, m_data, m_full);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
